// File: rtl/alu_pkg.sv
`default_nettype none
//==============================================================================
// Package : alu_pkg
// Shared ALU width, opcode encodings and sequencer FSM states.
// Rev     : 1.0
//==============================================================================
package alu_pkg;

    localparam int DATA_W = 18;

    localparam logic [2:0] OP_PASSA = 3'd0;
    localparam logic [2:0] OP_PASSB = 3'd1;
    localparam logic [2:0] OP_NOTA  = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_OR    = 3'd5;
    localparam logic [2:0] OP_AND   = 3'd6;
    localparam logic [2:0] OP_ILL   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_EXEC  = 2'd2,
        ST_CAPT  = 2'd3
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module : rr_arbiter
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
// Rev    : 1.0
//==============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               valid
);

    logic [IDX_W-1:0] k;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        k         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // rr_ptr is always < NUM_REQ, so one subtraction is enough to wrap
            if (int'(rr_ptr) + i >= NUM_REQ) begin
                k = IDX_W'(int'(rr_ptr) + i - NUM_REQ);
            end else begin
                k = IDX_W'(int'(rr_ptr) + i);
            end
            if (!valid && req[k]) begin
                valid     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = k;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/alu_sequencer_arb.sv
`default_nettype none
//==============================================================================
// Module : alu_sequencer_arb
// Round-robin sharing of one combinational ALU; 4-cycle gnt -> exec -> capture -> done.
// Rev    : 1.0
//==============================================================================
module alu_sequencer_arb
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = alu_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [3*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic [DATA_W-1:0]         res,
    output logic                      res_n,
    output logic                      res_z,
    output logic                      res_ovf,
    output logic                      res_agtb,
    output logic                      err,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [2:0]                alu_ctrl,
    output logic                      alu_en,
    input  logic [DATA_W-1:0]         alu_out,
    input  logic                      alu_n,
    input  logic                      alu_z,
    input  logic                      alu_ovf,
    input  logic                      alu_agtb
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;
    logic [NUM_REQ-1:0]   win_oh;
    logic [IDX_W-1:0]     win_idx;
    logic [2:0]           op_q;
    logic [DATA_W-1:0]    a_q;
    logic [DATA_W-1:0]    b_q;
    logic [DATA_W-1:0]    cap_res;
    logic                 cap_n;
    logic                 cap_z;
    logic                 cap_ovf;
    logic                 cap_agtb;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        alu_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                gnt       = win_oh;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                alu_en    = (op_q != OP_ILL);
                state_nxt = ST_CAPT;
            end
            ST_CAPT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE) || (|done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            win_oh   <= '0;
            win_idx  <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            cap_res  <= '0;
            cap_n    <= 1'b0;
            cap_z    <= 1'b0;
            cap_ovf  <= 1'b0;
            cap_agtb <= 1'b0;
            res      <= '0;
            res_n    <= 1'b0;
            res_z    <= 1'b0;
            res_ovf  <= 1'b0;
            res_agtb <= 1'b0;
            err      <= 1'b0;
            done     <= '0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        win_oh  <= arb_grant;
                        win_idx <= arb_idx;
                        op_q    <= req_op[int'(arb_idx)*3 +: 3];
                        a_q     <= req_a[int'(arb_idx)*DATA_W +: DATA_W];
                        b_q     <= req_b[int'(arb_idx)*DATA_W +: DATA_W];
                    end
                end
                ST_GRANT: begin
                    rr_ptr   <= (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
                    // ALU inputs only move here, so they hold outside EXEC
                    alu_a    <= a_q;
                    alu_b    <= b_q;
                    alu_ctrl <= op_q;
                end
                ST_EXEC: begin
                    // Sample while alu_en is still high; published with done one cycle later
                    if (op_q == OP_ILL) begin
                        cap_res  <= '0;
                        cap_n    <= 1'b0;
                        cap_z    <= 1'b0;
                        cap_ovf  <= 1'b0;
                        cap_agtb <= 1'b0;
                    end else begin
                        cap_res  <= alu_out;
                        cap_n    <= alu_n;
                        cap_z    <= alu_z;
                        cap_ovf  <= alu_ovf;
                        cap_agtb <= alu_agtb;
                    end
                end
                ST_CAPT: begin
                    res      <= cap_res;
                    res_n    <= cap_n;
                    res_z    <= cap_z;
                    res_ovf  <= cap_ovf;
                    res_agtb <= cap_agtb;
                    err      <= (op_q == OP_ILL);
                    done     <= win_oh;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : alu_sequencer_arb
`default_nettype wire
